// File: rtl/memory_rom.sv
// Preloaded 2^ADDR_W x DATA_W nibble store with a registered, read-first read port
// and a single write port; word[a] powers up holding the low nibble of a.
module memory_rom #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  input  logic              reset,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] mem_t [DEPTH];

  // Power-up image: each word holds the low bits of its own address.
  function automatic mem_t init_image();
    mem_t img;
    for (int unsigned a = 0; a < DEPTH; a++) begin
      img[a] = DATA_W'(a);
    end
    return img;
  endfunction

  mem_t              mem_q = init_image();
  logic [DATA_W-1:0] data_q;

  // Read-first: the read samples the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= mem_q[addr];
      if (we) begin
        mem_q[addr] <= wdata;
      end
    end
  end

  assign data = data_q;

endmodule

// File: tb/tb_memory_rom.sv
// Directed bench for memory_rom: power-up sweep, reset, write/read, read-during-write,
// reset-over-write and address wrap, each against hand-computed values.
module tb_memory_rom;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 4;

  logic              clk = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] data;
  logic              reset = 1'b1;
  logic              we = 1'b0;
  logic [DATA_W-1:0] wdata = '0;

  int total = 0;
  int bad   = 0;

  memory_rom #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .addr  (addr),
    .data  (data),
    .reset (reset),
    .we    (we),
    .wdata (wdata)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [DATA_W-1:0] got,
                           input logic [DATA_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, then sample just after the rising edge.
  task automatic cycle(input logic [ADDR_W-1:0] a, input logic rst, input logic w,
                       input logic [DATA_W-1:0] wd);
    @(negedge clk);
    addr  = a;
    reset = rst;
    we    = w;
    wdata = wd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DATA_W-1:0] exp_nib;

    cycle(16'h0000, 1'b1, 1'b0, 4'h0);
    check_val("reset_init", data, 4'h0);

    for (int k = 0; k < 1000; k++) begin
      cycle(ADDR_W'(k), 1'b0, 1'b0, 4'h0);
      exp_nib = DATA_W'(k);
      check_val("sweep", data, exp_nib);
    end

    cycle(16'h0005, 1'b1, 1'b0, 4'h0);
    check_val("reset_c0", data, 4'h0);
    cycle(16'h0005, 1'b1, 1'b0, 4'h0);
    check_val("reset_c1", data, 4'h0);
    cycle(16'h0005, 1'b0, 1'b0, 4'h0);
    check_val("reset_release", data, 4'h5);

    cycle(16'h1234, 1'b0, 1'b0, 4'h0);
    check_val("pre_write_1234", data, 4'h4);
    cycle(16'h1234, 1'b0, 1'b1, 4'hA);
    check_val("write_cycle_1234", data, 4'h4);
    cycle(16'h1234, 1'b0, 1'b0, 4'h0);
    check_val("read_1234", data, 4'hA);
    cycle(16'h1235, 1'b0, 1'b0, 4'h0);
    check_val("read_1235", data, 4'h5);

    cycle(16'h0010, 1'b0, 1'b1, 4'hC);
    check_val("rdw_old", data, 4'h0);
    cycle(16'h0010, 1'b0, 1'b0, 4'h0);
    check_val("rdw_new", data, 4'hC);

    cycle(16'h0020, 1'b1, 1'b1, 4'hF);
    check_val("reset_write", data, 4'h0);
    cycle(16'h0020, 1'b0, 1'b0, 4'h0);
    check_val("write_suppressed", data, 4'h0);

    cycle(16'hFFFF, 1'b0, 1'b0, 4'h0);
    check_val("wrap_ffff", data, 4'hF);
    cycle(16'h0000, 1'b0, 1'b0, 4'h0);
    check_val("wrap_0000", data, 4'h0);

    // Earlier writes persist and reset never touched the array.
    cycle(16'h1234, 1'b0, 1'b0, 4'h0);
    check_val("persist_1234", data, 4'hA);
    cycle(16'h0005, 1'b0, 1'b0, 4'h0);
    check_val("persist_0005", data, 4'h5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
